// File: rtl/mux_nx1_scan.sv
// Registered N:1 multiplexer with per-channel enable masking and a round-robin
// scan mode that dwells a programmable number of cycles on each enabled channel.
module mux_nx1_scan #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = $clog2(CHANNELS),
    parameter int unsigned DWELL    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS*WIDTH-1:0]   I,
    input  logic [SEL_W-1:0]            S,
    input  logic                        mode,
    input  logic [CHANNELS-1:0]         en_mask,
    input  logic                        hold,
    output logic [WIDTH-1:0]            Y,
    output logic [SEL_W-1:0]            Y_ch,
    output logic                        Y_vld,
    output logic                        wrap
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [WIDTH-1:0] y_q,     y_d;
    logic [SEL_W-1:0] y_ch_q,  y_ch_d;
    logic             y_vld_q, y_vld_d;
    logic             wrap_q,  wrap_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             mode_q,  mode_d;

    logic [WIDTH-1:0] s_data;
    logic             s_en;
    logic             s_ok;
    logic [WIDTH-1:0] p_data;
    logic             p_en;
    logic [SEL_W-1:0] nxt_ptr;
    logic             nxt_found;

    // Manual-select lookup; out-of-range selects match no channel.
    always_comb begin
        s_data = '0;
        s_en   = 1'b0;
        s_ok   = (32'(S) < CHANNELS);
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (S == SEL_W'(k)) begin
                s_data = I[k*WIDTH +: WIDTH];
                s_en   = en_mask[k];
            end
        end
    end

    // Scan-pointer lookup.
    always_comb begin
        p_data = '0;
        p_en   = 1'b0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (ptr_q == SEL_W'(k)) begin
                p_data = I[k*WIDTH +: WIDTH];
                p_en   = en_mask[k];
            end
        end
    end

    // Circular search for the next enabled channel, starting at ptr+1;
    // the last candidate is ptr itself, so a lone enabled channel re-selects itself.
    always_comb begin
        int unsigned idx;
        nxt_found = 1'b0;
        nxt_ptr   = ptr_q;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            for (int k = 0; k < int'(CHANNELS); k++) begin
                if (!nxt_found && (idx == 32'(k)) && en_mask[k]) begin
                    nxt_found = 1'b1;
                    nxt_ptr   = SEL_W'(k);
                end
            end
        end
    end

    // Next-state and output selection; hold freezes everything but clears wrap.
    always_comb begin
        y_d     = y_q;
        y_ch_d  = y_ch_q;
        y_vld_d = y_vld_q;
        wrap_d  = 1'b0;
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;

        if (!hold) begin
            mode_d = mode;
            if (!mode || !mode_q) begin
                y_ch_d  = S;
                y_vld_d = s_ok && s_en;
                y_d     = (s_ok && s_en) ? s_data : '0;
                if (mode) begin
                    ptr_d   = s_ok ? S : '0;
                    dwell_d = '0;
                end
            end else begin
                y_ch_d  = ptr_q;
                y_vld_d = p_en;
                y_d     = p_en ? p_data : '0;
                if (32'(dwell_q) < DWELL - 1) begin
                    dwell_d = dwell_q + DW_W'(1);
                end else begin
                    dwell_d = '0;
                    if (nxt_found) begin
                        ptr_d  = nxt_ptr;
                        wrap_d = (nxt_ptr <= ptr_q);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            y_ch_q  <= '0;
            y_vld_q <= 1'b0;
            wrap_q  <= 1'b0;
            ptr_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            y_ch_q  <= y_ch_d;
            y_vld_q <= y_vld_d;
            wrap_q  <= wrap_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
        end
    end

    assign Y     = y_q;
    assign Y_ch  = y_ch_q;
    assign Y_vld = y_vld_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: default 8x8/DWELL=4 instance plus a
// 5-channel, 12-bit, DWELL=1 instance.
module tb_mux_nx1_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: defaults
    logic        rst_a, mode_a, hold_a;
    logic [63:0] i_a;
    logic [2:0]  s_a;
    logic [7:0]  mask_a;
    logic [7:0]  y_a;
    logic [2:0]  ych_a;
    logic        yvld_a, wrap_a;

    mux_nx1_scan u_a (
        .clk(clk), .rst(rst_a), .I(i_a), .S(s_a), .mode(mode_a),
        .en_mask(mask_a), .hold(hold_a),
        .Y(y_a), .Y_ch(ych_a), .Y_vld(yvld_a), .wrap(wrap_a)
    );

    // Instance B: 5 channels, 12 bits, DWELL=1
    logic        rst_b, mode_b, hold_b;
    logic [59:0] i_b;
    logic [2:0]  s_b;
    logic [4:0]  mask_b;
    logic [11:0] y_b;
    logic [2:0]  ych_b;
    logic        yvld_b, wrap_b;

    mux_nx1_scan #(.WIDTH(12), .CHANNELS(5), .DWELL(1)) u_b (
        .clk(clk), .rst(rst_b), .I(i_b), .S(s_b), .mode(mode_b),
        .en_mask(mask_b), .hold(hold_b),
        .Y(y_b), .Y_ch(ych_b), .Y_vld(yvld_b), .wrap(wrap_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int ch, input int y, input int vld, input int wr);
        chk({tag, "_ch"},   32'(ych_a),  32'(ch));
        chk({tag, "_y"},    32'(y_a),    32'(y));
        chk({tag, "_vld"},  32'(yvld_a), 32'(vld));
        chk({tag, "_wrap"}, 32'(wrap_a), 32'(wr));
    endtask

    task automatic chk_b(input string tag, input int ch, input int y, input int vld, input int wr);
        chk({tag, "_ch"},   32'(ych_b),  32'(ch));
        chk({tag, "_y"},    32'(y_b),    32'(y));
        chk({tag, "_vld"},  32'(yvld_b), 32'(vld));
        chk({tag, "_wrap"}, 32'(wrap_b), 32'(wr));
    endtask

    int seq_full[8];
    int ch;

    initial begin
        for (int k = 0; k < 8; k++) i_a[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 5; k++) i_b[k*12 +: 12] = 12'(12'hA00 + k);
        seq_full = '{2, 3, 4, 5, 6, 7, 0, 1};

        // Reset with manual select 5 presented
        rst_a = 1'b1; s_a = 3'd5; mode_a = 1'b0; hold_a = 1'b0; mask_a = 8'hFF;
        rst_b = 1'b1; s_b = 3'd0; mode_b = 1'b0; hold_b = 1'b0; mask_b = 5'h1F;
        tick(); tick();
        chk_a("a_reset", 0, 0, 0, 0);
        chk_b("b_reset", 0, 0, 0, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
        chk_a("a_man5", 5, 'h15, 1, 0);

        // Manual masked channel, then neighbour
        mask_a = 8'hDF;
        tick();
        chk_a("a_man5_masked", 5, 0, 0, 0);
        s_a = 3'd6;
        tick();
        chk_a("a_man6", 6, 'h16, 1, 0);

        // Scan entry at S=2, full mask: entry cycle shows S, then 4 cycles per channel
        mask_a = 8'hFF; s_a = 3'd2; mode_a = 1'b1;
        tick();
        chk_a("a_entry", 2, 'h12, 1, 0);
        for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < 4; d++) begin
                tick();
                ch = seq_full[c];
                chk_a("a_scan_full", ch, 'h10 + ch, 1, (ch == 7 && d == 3) ? 1 : 0);
            end
        end

        // Mask 0x41 from ptr=2: ptr 2 disabled for its dwell, then 6 -> 0 -> 6
        mask_a = 8'h41;
        for (int d = 0; d < 4; d++) begin tick(); chk_a("a_skip_p2", 2, 0, 0, 0); end
        for (int d = 0; d < 4; d++) begin tick(); chk_a("a_skip_p6a", 6, 'h16, 1, (d == 3) ? 1 : 0); end
        for (int d = 0; d < 4; d++) begin tick(); chk_a("a_skip_p0", 0, 'h10, 1, 0); end
        for (int d = 0; d < 4; d++) begin tick(); chk_a("a_skip_p6b", 6, 'h16, 1, (d == 3) ? 1 : 0); end

        // Single enabled channel 3: ptr 0 dwell, then 3 re-selecting itself with wrap
        mask_a = 8'h08;
        for (int d = 0; d < 4; d++) begin tick(); chk_a("a_single_p0", 0, 0, 0, 0); end
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin tick(); chk_a("a_single_p3", 3, 'h13, 1, (d == 3) ? 1 : 0); end
        end

        // Empty mask: pointer holds, no valid data, no wrap
        mask_a = 8'h00;
        for (int d = 0; d < 8; d++) begin tick(); chk_a("a_empty", 3, 0, 0, 0); end

        // Two dwell cycles on 3, then hold for 10 cycles with mode dropped
        mask_a = 8'hFF;
        for (int d = 0; d < 2; d++) begin tick(); chk_a("a_prehold", 3, 'h13, 1, 0); end
        hold_a = 1'b1; mode_a = 1'b0; s_a = 3'd1;
        for (int d = 0; d < 10; d++) begin tick(); chk_a("a_hold", 3, 'h13, 1, 0); end
        // Release in scan: dwell resumes with two cycles left on channel 3
        hold_a = 1'b0; mode_a = 1'b1;
        for (int d = 0; d < 2; d++) begin tick(); chk_a("a_resume", 3, 'h13, 1, 0); end
        tick();
        chk_a("a_resume_next", 4, 'h14, 1, 0);
        // Mode change to manual during hold applies only after release
        hold_a = 1'b1; mode_a = 1'b0;
        for (int d = 0; d < 3; d++) begin tick(); chk_a("a_hold2", 4, 'h14, 1, 0); end
        hold_a = 1'b0;
        tick();
        chk_a("a_manual_after_hold", 1, 'h11, 1, 0);

        // Async reset between edges clears outputs immediately, even under hold
        hold_a = 1'b1;
        #2 rst_a = 1'b1;
        #1 chk_a("a_async_rst", 0, 0, 0, 0);
        tick();
        rst_a = 1'b0; hold_a = 1'b0;

        // Instance B: DWELL=1 scan advances every cycle, wrap on 4 -> 0
        mode_b = 1'b1; s_b = 3'd0;
        tick();
        chk_b("b_entry", 0, 'hA00, 1, 0);
        for (int n = 0; n < 10; n++) begin
            tick();
            ch = n % 5;
            chk_b("b_scan", ch, 'hA00 + ch, 1, (ch == 4) ? 1 : 0);
        end

        // Out-of-range manual select is never valid
        mode_b = 1'b0; s_b = 3'd6;
        tick();
        chk_b("b_man6", 6, 0, 0, 0);
        s_b = 3'd4;
        tick();
        chk_b("b_man4", 4, 'hA04, 1, 0);

        // Scan entry at 3, async reset mid-scan, re-entry from new S
        s_b = 3'd3; mode_b = 1'b1;
        tick(); chk_b("b_entry3", 3, 'hA03, 1, 0);
        tick(); chk_b("b_scan3", 3, 'hA03, 1, 0);
        tick(); chk_b("b_scan4", 4, 'hA04, 1, 1);
        #2 rst_b = 1'b1;
        #1 chk_b("b_async_rst", 0, 0, 0, 0);
        s_b = 3'd1;
        tick();
        rst_b = 1'b0;
        tick(); chk_b("b_reentry", 1, 'hA01, 1, 0);
        tick(); chk_b("b_rescan1", 1, 'hA01, 1, 0);
        tick(); chk_b("b_rescan2", 2, 'hA02, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
